// File: rtl/cosim_sb_pkg.sv
// Shared types and helpers for the co-simulation stream scoreboard.
// Holds the control FSM state encoding plus popcount and saturating add.
package cosim_sb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of set bits in a lane vector (up to 16 lanes).
    function automatic logic [31:0] popcount(input logic [15:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

    // a + b clamped to the largest value that fits in w bits.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned w
    );
        logic [32:0] s;
        logic [32:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = (33'd1 << w) - 33'd1;
        return (s > mx) ? mx[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/cosim_sb_fifo.sv
// Single-clock golden-token FIFO for one scoreboard lane.
// Pointers carry an extra MSB so full and empty are distinguishable.
module cosim_sb_fifo
    import cosim_sb_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop; reset discards contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage write; no reset needed since empty gates every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/cosim_stream_scoreboard.sv
// N-lane clocked scoreboard pairing golden tokens with DUT tokens in order.
// Optional stall timeout enabled by defining COSIM_SCOREBOARD_TIMEOUT_EN.
module cosim_stream_scoreboard
    import cosim_sb_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 2,
    parameter int DEPTH = 8,
`ifdef COSIM_SCOREBOARD_TIMEOUT_EN
    parameter int TMO   = 1024,
`endif
    parameter int CNTW  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  enable,
    input  logic [N-1:0]          gold_valid,
    output logic [N-1:0]          gold_ready,
    input  logic [N*W-1:0]        gold_data,
    input  logic [N-1:0]          dut_valid,
    output logic [N-1:0]          dut_ready,
    input  logic [N*W-1:0]        dut_data,
    output logic [CNTW-1:0]       match_cnt,
    output logic [CNTW-1:0]       err_cnt,
    output logic                  mismatch,
    output logic [$clog2(N):0]    mm_lane,
    output logic [W-1:0]          mm_expected,
    output logic [W-1:0]          mm_actual,
`ifdef COSIM_SCOREBOARD_TIMEOUT_EN
    output logic                  timeout,
`endif
    output logic                  done
);

    localparam int LW = $clog2(N) + 1;

    state_t           state_q, state_d;
    logic [N-1:0]     full, empty, push, pop, eq;
    logic [N*W-1:0]   head;
    logic             drain_exit;

    logic [N-1:0]     cmp_match_q, cmp_mis_q;
    logic [N*W-1:0]   cmp_gold_q, cmp_dut_q;

    logic [CNTW-1:0]  match_cnt_q, err_cnt_q;
    logic             mismatch_q;
    logic [LW-1:0]    mm_lane_q, first_lane;
    logic [W-1:0]     mm_exp_q, mm_act_q, first_exp, first_act;

    assign push = gold_valid & gold_ready;
    assign pop  = dut_valid & dut_ready;

    for (genvar g = 0; g < N; g++) begin : g_lane
        cosim_sb_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (CLK),
            .rst_i   (RESET),
            .push_i  (push[g]),
            .wdata_i (gold_data[g*W +: W]),
            .pop_i   (pop[g]),
            .rdata_o (head[g*W +: W]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
        assign eq[g] = (head[g*W +: W] == dut_data[g*W +: W]);
    end

`ifdef COSIM_SCOREBOARD_TIMEOUT_EN
    localparam int SW = $clog2(TMO + 1);

    logic [SW-1:0] stall_q [N];
    logic [SW-1:0] stall_d [N];
    logic          tmo_hit;
    logic          timeout_q;

    // Per-lane stall count: golden token waiting with no DUT token offered.
    always_comb begin
        tmo_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            stall_d[i] = stall_q[i];
            if (pop[i]) begin
                stall_d[i] = '0;
            end else if (!empty[i] && !dut_valid[i] &&
                         stall_q[i] != SW'(TMO)) begin
                stall_d[i] = stall_q[i] + 1'b1;
            end
            if (stall_d[i] == SW'(TMO)) begin
                tmo_hit = 1'b1;
            end
        end
    end

    // Stall counters and the sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                stall_q[i] <= '0;
            end
            timeout_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                stall_q[i] <= stall_d[i];
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout    = timeout_q;
    assign drain_exit = (&empty) || timeout_q;
`else
    assign drain_exit = &empty;
`endif

    // Control state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and lane handshakes.
    always_comb begin
        state_d    = state_q;
        gold_ready = '0;
        dut_ready  = '0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                gold_ready = ~full;
                dut_ready  = ~empty;
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                dut_ready = ~empty;
                if (drain_exit) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (enable) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Compare stage: register per-lane outcome of each accepted DUT token.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmp_match_q <= '0;
            cmp_mis_q   <= '0;
            cmp_gold_q  <= '0;
            cmp_dut_q   <= '0;
        end else begin
            cmp_match_q <= pop & eq;
            cmp_mis_q   <= pop & ~eq;
            cmp_gold_q  <= head;
            cmp_dut_q   <= dut_data;
        end
    end

    // Lowest-index mismatching lane from the compare stage.
    always_comb begin
        first_lane = '0;
        first_exp  = '0;
        first_act  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cmp_mis_q[i]) begin
                first_lane = LW'(i);
                first_exp  = cmp_gold_q[i*W +: W];
                first_act  = cmp_dut_q[i*W +: W];
            end
        end
    end

    // Saturating counters and frozen first-mismatch capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            mismatch_q  <= 1'b0;
            mm_lane_q   <= '0;
            mm_exp_q    <= '0;
            mm_act_q    <= '0;
        end else begin
            match_cnt_q <= CNTW'(sat_add(32'(match_cnt_q),
                           popcount(16'(cmp_match_q)), CNTW));
            err_cnt_q   <= CNTW'(sat_add(32'(err_cnt_q),
                           popcount(16'(cmp_mis_q)), CNTW));
            if (!mismatch_q && |cmp_mis_q) begin
                mismatch_q <= 1'b1;
                mm_lane_q  <= first_lane;
                mm_exp_q   <= first_exp;
                mm_act_q   <= first_act;
            end
        end
    end

    assign match_cnt   = match_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign mismatch    = mismatch_q;
    assign mm_lane     = mm_lane_q;
    assign mm_expected = mm_exp_q;
    assign mm_actual   = mm_act_q;

endmodule
